// File: rtl/pwm_pulse_tx.sv
// RC-style PWM frame generator: one high pulse of the commanded width per fixed-length frame.
// A shadow width is latched on writes and applied only at frame start; a frame watchdog falls back to failsafe.
module pwm_pulse_tx #(
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int FAILSAFE_US = 1000,
    parameter int WD_FRAMES   = 50
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [11:0] WIDTH_IN,
    input  logic        WIDTH_VALID,
    output logic        PWM_OUT,
    output logic        FRAME_START,
    output logic        FAILSAFE,
    output logic [11:0] WIDTH_ACTIVE
);

    localparam logic [11:0] MIN_W       = 12'(MIN_US);
    localparam logic [11:0] MAX_W       = 12'(MAX_US);
    localparam logic [11:0] FAILSAFE_W  = 12'(FAILSAFE_US);
    localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_US - 1);
    localparam logic [7:0]  WD_MAX      = 8'(WD_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t      state_reg, state_next;
    logic        frame_start_next;
    logic [15:0] frame_cnt_reg;
    logic [11:0] high_cnt_reg;
    logic [11:0] shadow_reg;
    logic [11:0] width_active_reg;
    logic [11:0] width_clamped;
    logic [7:0]  wd_cnt_reg;
    logic        failsafe_reg;
    logic        pwm_reg;
    logic        frame_start_reg;

    always_comb begin
        width_clamped = WIDTH_IN;
        if (WIDTH_IN < MIN_W)
            width_clamped = MIN_W;
        else if (WIDTH_IN > MAX_W)
            width_clamped = MAX_W;
    end

    always_comb begin
        state_next       = state_reg;
        frame_start_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ENABLE) begin
                    frame_start_next = 1'b1;
                    state_next       = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // width_active_reg is never below 1, so this always terminates the pulse
                if (high_cnt_reg == width_active_reg - 12'd1)
                    state_next = ST_LOW;
            end
            ST_LOW: begin
                if (frame_cnt_reg == PERIOD_LAST) begin
                    if (ENABLE) begin
                        frame_start_next = 1'b1;
                        state_next       = ST_HIGH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg        <= ST_IDLE;
            pwm_reg          <= 1'b0;
            frame_start_reg  <= 1'b0;
            failsafe_reg     <= 1'b1;
            shadow_reg       <= FAILSAFE_W;
            width_active_reg <= FAILSAFE_W;
            wd_cnt_reg       <= WD_MAX;
            frame_cnt_reg    <= 16'd0;
            high_cnt_reg     <= 12'd0;
        end else begin
            state_reg       <= state_next;
            pwm_reg         <= (state_next == ST_HIGH);
            frame_start_reg <= frame_start_next;

            if (frame_start_next) begin
                frame_cnt_reg <= 16'd0;
                high_cnt_reg  <= 12'd0;
                // shadow_reg here is still the pre-write value if a write lands this cycle
                if (wd_cnt_reg == WD_MAX) begin
                    width_active_reg <= FAILSAFE_W;
                    failsafe_reg     <= 1'b1;
                end else begin
                    width_active_reg <= shadow_reg;
                    failsafe_reg     <= 1'b0;
                end
            end else if (state_reg != ST_IDLE) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                high_cnt_reg  <= high_cnt_reg + 12'd1;
            end

            if (WIDTH_VALID) begin
                shadow_reg <= width_clamped;
                wd_cnt_reg <= 8'd0;
            end else if (frame_start_next && wd_cnt_reg != WD_MAX) begin
                wd_cnt_reg <= wd_cnt_reg + 8'd1;
            end
        end
    end

    assign PWM_OUT      = pwm_reg;
    assign FRAME_START  = frame_start_reg;
    assign FAILSAFE     = failsafe_reg;
    assign WIDTH_ACTIVE = width_active_reg;

endmodule
